// File: rtl/alu_multicycle.sv
// Multicycle ALU with single-cycle ADD/SUB/AND/OR/XOR/SLL/SRA and an iterative shift-add MUL.
// The multiplier exists only when ALU_MUL_EN is defined; otherwise code 111 completes in one cycle with a zero result.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] OperA,
  input  logic [WIDTH-1:0] OperB,
  input  logic [2:0]       ALU_Code,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_sll;
  logic [WIDTH:0]   w_sra;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_hi_nz;

  // The extra bit on each shift captures the last bit shifted out (zero for a shift of 0).
  assign w_shamt     = OperB[SHW-1:0];
  assign w_add       = {1'b0, OperA} + {1'b0, OperB};
  assign w_sub       = {1'b0, OperA} - {1'b0, OperB};
  assign w_sll       = {1'b0, OperA} << w_shamt;
  assign w_sra       = $signed({OperA, 1'b0}) >>> w_shamt;
  assign w_accept    = (r_state == S_IDLE) && Start;
  assign w_is_mul    = (ALU_Code == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul && MUL_EN;

  // Single-cycle result and carry/overflow selection.
  always_comb begin
    w_res   = {WIDTH{1'b0}};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (ALU_Code)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (OperA[WIDTH-1] == OperB[WIDTH-1]) && (w_add[WIDTH-1] != OperA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = ~w_sub[WIDTH];
        w_ovf   = (OperA[WIDTH-1] != OperB[WIDTH-1]) && (w_sub[WIDTH-1] != OperA[WIDTH-1]);
      end
      OP_AND: w_res = OperA & OperB;
      OP_OR:  w_res = OperA | OperB;
      OP_XOR: w_res = OperA ^ OperB;
      OP_SLL: begin
        w_res   = w_sll[WIDTH-1:0];
        w_carry = w_sll[WIDTH];
      end
      OP_SRA: begin
        w_res   = w_sra[WIDTH:1];
        w_carry = w_sra[0];
      end
      OP_MUL: begin
        w_res   = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
      default: begin
        w_res   = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  // State register; Busy mirrors the next state so it is high exactly while in S_MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      Busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      Busy    <= (w_state_next == S_MUL);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mul_start) w_state_next = S_MUL;
        else             w_state_next = S_IDLE;
      end
      S_MUL: begin
        if (w_mul_last) w_state_next = S_IDLE;
        else            w_state_next = S_MUL;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;

  // One multiplier bit per cycle; the final iteration's sum feeds Result directly.
  always_comb begin
    if (r_mplier[0]) w_acc_next = r_acc + r_mcand;
    else             w_acc_next = r_acc;
  end

  // Multiplier datapath; operands are frozen at Start and only shifted afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_cnt    <= {SHW{1'b0}};
    end else if (w_mul_start) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {{WIDTH{1'b0}}, OperA};
      r_mplier <= OperB;
      r_cnt    <= {SHW{1'b0}};
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
    end else begin
      r_acc    <= r_acc;
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_cnt    <= r_cnt;
    end
  end

  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));
  assign w_mul_lo    = w_acc_next[WIDTH-1:0];
  assign w_mul_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];
`else
  assign w_mul_last  = 1'b0;
  assign w_mul_lo    = {WIDTH{1'b0}};
  assign w_mul_hi_nz = 1'b0;
`endif

  // Result/flag registers and the Done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      Result   <= {WIDTH{1'b0}};
      Zero     <= 1'b1;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else if (w_accept && !w_mul_start) begin
      Result   <= w_res;
      Zero     <= (w_res == {WIDTH{1'b0}});
      Negative <= w_res[WIDTH-1];
      Carry    <= w_carry;
      Overflow <= w_ovf;
      Done     <= 1'b1;
    end else if (w_mul_last) begin
      Result   <= w_mul_lo;
      Zero     <= (w_mul_lo == {WIDTH{1'b0}});
      Negative <= w_mul_lo[WIDTH-1];
      Carry    <= w_mul_hi_nz;
      Overflow <= w_mul_hi_nz;
      Done     <= 1'b1;
    end else begin
      Done     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus randomized ops against an arithmetic reference model.
// Honours ALU_MUL_EN the same way the design does.
module tb_alu_multicycle;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 32;
`else
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] oper_a = 32'd0;
  logic [31:0] oper_b = 32'd0;
  logic [2:0]  alu_code = 3'd0;
  logic [31:0] result;
  logic        zero, negative, carry, overflow, busy, done;

  logic        start8 = 1'b0;
  logic [7:0]  oper_a8 = 8'd0;
  logic [7:0]  oper_b8 = 8'd0;
  logic [2:0]  alu_code8 = 3'd0;
  logic [7:0]  result8;
  logic        zero8, negative8, carry8, overflow8, busy8, done8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(start), .OperA(oper_a), .OperB(oper_b), .ALU_Code(alu_code),
    .Result(result), .Zero(zero), .Negative(negative), .Carry(carry), .Overflow(overflow),
    .Busy(busy), .Done(done)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .Start(start8), .OperA(oper_a8), .OperB(oper_b8), .ALU_Code(alu_code8),
    .Result(result8), .Zero(zero8), .Negative(negative8), .Carry(carry8), .Overflow(overflow8),
    .Busy(busy8), .Done(done8)
  );

  // Reference model: operands are already w bits wide, zero-extended to 64.
  function automatic exp_t model(input int w, input logic [2:0] code, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] mask;
    logic [127:0] x;
    logic [127:0] p;
    int sh;
    exp_t e;
    mask = (128'd1 << w) - 128'd1;
    sh = int'(b[5:0]) % w;
    x = 128'd0;
    p = 128'd0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (code)
      3'd0: begin
        x = {64'd0, a} + {64'd0, b};
        e.c = x[w];
        x = x & mask;
        e.v = (a[w-1] == b[w-1]) && (x[w-1] != a[w-1]);
      end
      3'd1: begin
        x = ({64'd0, a} - {64'd0, b}) & mask;
        e.c = (a >= b);
        e.v = (a[w-1] != b[w-1]) && (x[w-1] != a[w-1]);
      end
      3'd2: x = {64'd0, a & b};
      3'd3: x = {64'd0, a | b};
      3'd4: x = {64'd0, a ^ b};
      3'd5: begin
        x = {64'd0, a};
        for (int i = 0; i < sh; i++) begin
          e.c = x[w-1];
          x = (x << 1) & mask;
        end
      end
      3'd6: begin
        x = {64'd0, a};
        for (int i = 0; i < sh; i++) begin
          e.c = x[0];
          x = (x >> 1) | (x[w-1] ? (128'd1 << (w - 1)) : 128'd0);
        end
      end
      default: begin
`ifdef ALU_MUL_EN
        p = {64'd0, a} * {64'd0, b};
        x = p & mask;
        e.c = ((p >> w) != 128'd0);
        e.v = e.c;
`else
        x = 128'd0;
        p = 128'd0;
`endif
      end
    endcase
    e.r = x[63:0];
    e.z = (x == 128'd0);
    e.n = x[w-1];
    return e;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic send(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    alu_code = code;
    oper_a   = a;
    oper_b   = b;
  endtask

  // Waits for Done at negedges; with noise, drives random Start/operands while waiting.
  task automatic wait_done(input bit noise, output int lat, output int busy_n);
    bit seen;
    seen = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
          oper_a = 32'($urandom);
          oper_b = 32'($urandom);
          alu_code = 3'($urandom_range(0, 7));
        end
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send(3'd0, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({result, zero, negative, carry, overflow} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_outputs got=%h/%b%b%b%b exp=0/1000", result, zero, negative, carry, overflow);
    else n_pass++;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got=%b%b exp=00", busy, done);
    else n_pass++;
    n_checks++;
    if ({result8, zero8, busy8, done8} !== {8'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_w8 got=%h/%b%b%b exp=00/100", result8, zero8, busy8, done8);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_no_done got=%b exp=0", done);
    else n_pass++;
  endtask

  task automatic test_directed();
    int lat, bn;
    @(negedge clk);
    send(3'd0, 32'hFFFF_FFFF, 32'd1);
    wait_done(1'b0, lat, bn);
    n_checks++;
    if ({result, zero, carry, overflow, lat} !== {32'd0, 1'b1, 1'b1, 1'b0, 32'd1})
      $display("FAIL add_wrap got=%h z%b c%b v%b lat%0d exp=0 z1 c1 v0 lat1", result, zero, carry, overflow, lat);
    else n_pass++;
    @(negedge clk);
    send(3'd1, 32'h8000_0000, 32'd1);
    wait_done(1'b0, lat, bn);
    n_checks++;
    if ({result, overflow, carry, negative} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0})
      $display("FAIL sub_ovf got=%h v%b c%b n%b exp=7fffffff v1 c1 n0", result, overflow, carry, negative);
    else n_pass++;
    @(negedge clk);
    send(3'd5, 32'hFFFF_FFFF, 32'h0000_0020);
    wait_done(1'b0, lat, bn);
    n_checks++;
    if ({result, carry, negative} !== {32'hFFFF_FFFF, 1'b0, 1'b1})
      $display("FAIL sll_zero_shift got=%h c%b n%b exp=ffffffff c0 n1", result, carry, negative);
    else n_pass++;
  endtask

  task automatic test_width8();
    exp_t e;
    logic [2:0] code;
    logic [7:0] a, b;
    @(negedge clk);
    start8 = 1'b1; alu_code8 = 3'd6; oper_a8 = 8'h90; oper_b8 = 8'h03;
    @(negedge clk);
    start8 = 1'b0;
    n_checks++;
    if ({done8, result8, carry8} !== {1'b1, 8'hF2, 1'b0})
      $display("FAIL w8_sra got=d%b %h c%b exp=d1 f2 c0", done8, result8, carry8);
    else n_pass++;
    @(negedge clk);
    start8 = 1'b1; alu_code8 = 3'd5; oper_a8 = 8'h81; oper_b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    n_checks++;
    if ({done8, result8, carry8} !== {1'b1, 8'h02, 1'b1})
      $display("FAIL w8_sll got=d%b %h c%b exp=d1 02 c1", done8, result8, carry8);
    else n_pass++;
    for (int i = 0; i < 24; i++) begin
      code = 3'($urandom_range(0, 6));
      a = 8'($urandom);
      b = 8'($urandom);
      e = model(8, code, {56'd0, a}, {56'd0, b});
      @(negedge clk);
      start8 = 1'b1; alu_code8 = code; oper_a8 = a; oper_b8 = b;
      @(negedge clk);
      start8 = 1'b0;
      n_checks++;
      if ({done8, result8, zero8, negative8, carry8, overflow8} !== {1'b1, e.r[7:0], e.z, e.n, e.c, e.v})
        $display("FAIL w8_rand op=%0d a=%h b=%h got=d%b %h %b%b%b%b exp=d1 %h %b%b%b%b", code, a, b,
                 done8, result8, zero8, negative8, carry8, overflow8, e.r[7:0], e.z, e.n, e.c, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [2:0] code;
    logic [31:0] a, b;
    int lat, bn, exp_lat, exp_busy;
    for (int i = 0; i < 60; i++) begin
      code = 3'($urandom_range(0, 7));
      a = rnd32();
      b = rnd32();
      if (code == 3'd5 || code == 3'd6) b = 32'($urandom);
      e = model(32, code, {32'd0, a}, {32'd0, b});
      exp_lat  = (code == 3'd7) ? MUL_LAT : 1;
      exp_busy = (code == 3'd7) ? MUL_BUSY : 0;
      @(negedge clk);
      send(code, a, b);
      wait_done(1'b0, lat, bn);
      n_checks++;
      if (result !== e.r[31:0]) $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", code, a, b, result, e.r[31:0]);
      else n_pass++;
      n_checks++;
      if ({zero, negative, carry, overflow} !== {e.z, e.n, e.c, e.v})
        $display("FAIL rand_flags op=%0d a=%h b=%h got=%b%b%b%b exp=%b%b%b%b", code, a, b,
                 zero, negative, carry, overflow, e.z, e.n, e.c, e.v);
      else n_pass++;
      n_checks++;
      if (lat !== exp_lat || bn !== exp_busy)
        $display("FAIL rand_timing op=%0d got lat=%0d busy=%0d exp lat=%0d busy=%0d", code, lat, bn, exp_lat, exp_busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL rand_done_pulse op=%0d got=%b exp=0", code, done);
      else n_pass++;
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int lat, bn;
    e = model(32, 3'd7, 64'h1_0000, 64'h1_0000);
    @(negedge clk);
    send(3'd7, 32'h0001_0000, 32'h0001_0000);
    wait_done(1'b1, lat, bn);
    n_checks++;
    if ({result, zero, negative, carry, overflow} !== {e.r[31:0], e.z, e.n, e.c, e.v})
      $display("FAIL mul_ovf got=%h %b%b%b%b exp=%h %b%b%b%b", result, zero, negative, carry, overflow,
               e.r[31:0], e.z, e.n, e.c, e.v);
    else n_pass++;
    n_checks++;
    if (lat !== MUL_LAT || bn !== MUL_BUSY)
      $display("FAIL mul_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", lat, bn, MUL_LAT, MUL_BUSY);
    else n_pass++;
    e = model(32, 3'd7, 64'd251, 64'd252);
    @(negedge clk);
    send(3'd7, 32'd251, 32'd252);
    wait_done(1'b1, lat, bn);
    n_checks++;
    if ({result, carry} !== {e.r[31:0], e.c}) $display("FAIL mul_noise got=%h c%b exp=%h c%b", result, carry, e.r[31:0], e.c);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL mul_no_spurious got=%b%b exp=00", busy, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e [8];
    logic [2:0] code [8];
    int lat, bn, exp_lat;
    for (int i = 0; i < 8; i++) begin
      code[i] = (i == 2) ? 3'd7 : 3'($urandom_range(0, 6));
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      oper_a = rnd32();
      oper_b = 32'($urandom);
      e[i] = model(32, code[i], {32'd0, oper_a}, {32'd0, oper_b});
      send(code[i], oper_a, oper_b);
      wait_done(1'b0, lat, bn);
      exp_lat = (code[i] == 3'd7) ? MUL_LAT : 1;
      n_checks++;
      if ({result, zero, negative, carry, overflow, lat} !== {e[i].r[31:0], e[i].z, e[i].n, e[i].c, e[i].v, exp_lat})
        $display("FAIL b2b op#%0d code=%0d got=%h %b%b%b%b lat%0d exp=%h %b%b%b%b lat%0d", i, code[i], result,
                 zero, negative, carry, overflow, lat, e[i].r[31:0], e[i].z, e[i].n, e[i].c, e[i].v, exp_lat);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    int lat, bn, cnt, done_seen;
    @(negedge clk);
    send(3'd7, 32'd251, 32'd252);
`ifdef ALU_MUL_EN
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) cnt++;
    end
    n_checks++;
    if (cnt !== 10) $display("FAIL abort_reach_busy got=%0d exp=10", cnt);
    else n_pass++;
`else
    wait_done(1'b0, lat, bn);
    n_checks++;
    if ({bn, result} !== {32'd0, 32'd0}) $display("FAIL nomul_single got busy=%0d res=%h exp busy=0 res=0", bn, result);
    else n_pass++;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, result, zero} !== {1'b0, 1'b0, 32'd0, 1'b1})
      $display("FAIL abort_state got=b%b d%b %h z%b exp=b0 d0 0 z1", busy, done, result, zero);
    else n_pass++;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", done_seen);
    else n_pass++;
    send(3'd0, 32'd255, 32'd255);
    wait_done(1'b0, lat, bn);
    n_checks++;
    if ({result, lat} !== {32'd510, 32'd1}) $display("FAIL abort_then_add got=%0d lat%0d exp=510 lat1", result, lat);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_width8();
    test_random();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
